// File: rtl/wb_flash_rd_cntrlr_pkg.sv
// Shared definitions for the Wishbone NOR-flash read controller.
//   state_e             : FSM state encodings (IDLE, WAIT1, WAIT2, ACK, PREF).
//   WaitCycMin/Max      : legal range of the WAIT_CYC access-time parameter.
//   fmt_single()        : byte-lane / aligned-word formatting of one flash word.
package wb_flash_rd_cntrlr_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait1 = 3'd1,
    StWait2 = 3'd2,
    StAck   = 3'd3,
    StPref  = 3'd4
  } state_e;

  localparam int unsigned WaitCycMin = 1;
  localparam int unsigned WaitCycMax = 15;

  // Result of a single-access read: full word, or the selected byte zero-extended.
  function automatic logic [15:0] fmt_single(input logic byte_op, input logic odd,
                                             input logic [15:0] w);
    if (!byte_op) return w;
    return {8'h00, odd ? w[15:8] : w[7:0]};
  endfunction

endpackage

// File: rtl/flash_wait_cnt.sv
// 4-bit loadable down-counter used to time flash accesses.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i this edge
//   load_val_i : value to load
//   done_o     : count is zero
module flash_wait_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/wb_flash_rd_cntrlr.sv
// Wishbone read-only controller for the parallel NOR flash (Zet BIOS/ROM fetches).
// Byte reads, aligned word reads, and unaligned word reads (two flash accesses).
// Optional macro FLASH_PREFETCH_EN: after each ack, prefetch the next flash word
// into a one-entry buffer that can satisfy the following request.
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-high)     clock / reset
//   wb_stb_i, wb_cyc_i, wb_adr_i, wb_byte_i    Wishbone request (byte address)
//   wb_dat_o, wb_ack_o                         read data, single-cycle ack
//   NF_WE, NF_BYTE                             tied high (read-only, x16 mode)
//   NF_CE, NF_OE                               active-low, asserted only during access
//   NF_A[21:1], NF_D                           flash word address / data
module wb_flash_rd_cntrlr #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned PAGE     = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic              wb_byte_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              NF_WE,
  output logic              NF_BYTE,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic [21:1]       NF_A,
  input  logic [15:0]       NF_D
);

  import wb_flash_rd_cntrlr_pkg::*;

  localparam int unsigned WaW   = ADDR_W - 1;
  localparam int unsigned PageW = 22 - ADDR_W;
  localparam logic [PageW-1:0] PageBits = PageW'(PAGE);
  localparam logic [3:0] LoadVal = 4'(WAIT_CYC - 1);

  if (WAIT_CYC < WaitCycMin || WAIT_CYC > WaitCycMax) begin : g_bad_wait_cyc
    $error("WAIT_CYC must be within 1..15");
  end

  state_e           state_q, state_d;
  logic [WaW-1:0]   a_q, a_d;       // word address on NF_A (window part only)
  logic [WaW-1:0]   wa_q, wa_d;
  logic             byte_q, byte_d;
  logic             odd_q, odd_d;
  logic [15:0]      w0_q, w0_d;
  logic [15:0]      dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             ce_n_q, ce_n_d;  // drives both NF_CE and NF_OE
  logic             cnt_load, cnt_done;
  logic             req, accept;
  logic [WaW-1:0]   req_wa;

`ifdef FLASH_PREFETCH_EN
  logic [15:0]      pbuf_q, pbuf_d;
  logic [WaW-1:0]   paddr_q, paddr_d;
  logic             pvalid_q, pvalid_d;
`endif

  assign req    = wb_stb_i & wb_cyc_i;
  assign req_wa = wb_adr_i[ADDR_W-1:1];

`ifdef FLASH_PREFETCH_EN
  // A request arriving during PREF aborts the prefetch and starts immediately.
  assign accept = req & ~ack_q & ((state_q == StIdle) | (state_q == StPref));
`else
  assign accept = req & ~ack_q & (state_q == StIdle);
`endif

  flash_wait_cnt u_wait_cnt (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (cnt_load),
    .load_val_i (LoadVal),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    wa_d     = wa_q;
    byte_d   = byte_q;
    odd_d    = odd_q;
    w0_d     = w0_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    ce_n_d   = ce_n_q;
    cnt_load = 1'b0;
`ifdef FLASH_PREFETCH_EN
    pbuf_d   = pbuf_q;
    paddr_d  = paddr_q;
    pvalid_d = pvalid_q;
`endif

    if (accept) begin
      wa_d     = req_wa;
      byte_d   = wb_byte_i;
      odd_d    = wb_adr_i[0];
      a_d      = req_wa;
      ce_n_d   = 1'b0;
      cnt_load = 1'b1;
      state_d  = StWait1;
`ifdef FLASH_PREFETCH_EN
      if (state_q == StPref) begin
        pvalid_d = 1'b0;
      end else if (pvalid_q && (paddr_q == req_wa)) begin
        // Prefetch hit: the buffered word stands in for the WAIT1 access.
        if (!wb_byte_i && wb_adr_i[0]) begin
          w0_d    = pbuf_q;
          a_d     = req_wa + WaW'(1);
          state_d = StWait2;
        end else begin
          dat_d    = fmt_single(wb_byte_i, wb_adr_i[0], pbuf_q);
          ack_d    = 1'b1;
          ce_n_d   = 1'b1;
          cnt_load = 1'b0;
          state_d  = StAck;
        end
      end
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StWait1: begin
          if (!req) begin
            state_d = StIdle;
            ce_n_d  = 1'b1;
          end else if (cnt_done) begin
            w0_d = NF_D;
            if (!byte_q && odd_q) begin
              a_d      = a_q + WaW'(1);  // wraps inside the window
              cnt_load = 1'b1;
              state_d  = StWait2;
            end else begin
              dat_d   = fmt_single(byte_q, odd_q, NF_D);
              ack_d   = 1'b1;
              ce_n_d  = 1'b1;
              state_d = StAck;
            end
          end
        end
        StWait2: begin
          if (!req) begin
            state_d = StIdle;
            ce_n_d  = 1'b1;
          end else if (cnt_done) begin
            dat_d   = {NF_D[7:0], w0_q[15:8]};
            ack_d   = 1'b1;
            ce_n_d  = 1'b1;
            state_d = StAck;
          end
        end
        StAck: begin
`ifdef FLASH_PREFETCH_EN
          a_d      = a_q + WaW'(1);
          ce_n_d   = 1'b0;
          cnt_load = 1'b1;
          pvalid_d = 1'b0;
          state_d  = StPref;
`else
          state_d  = StIdle;
`endif
        end
`ifdef FLASH_PREFETCH_EN
        StPref: begin
          if (cnt_done) begin
            pbuf_d   = NF_D;
            paddr_d  = a_q;
            pvalid_d = 1'b1;
            ce_n_d   = 1'b1;
            state_d  = StIdle;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          ce_n_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      wa_q     <= '0;
      byte_q   <= 1'b0;
      odd_q    <= 1'b0;
      w0_q     <= 16'h0000;
      dat_q    <= 16'h0000;
      ack_q    <= 1'b0;
      ce_n_q   <= 1'b1;
`ifdef FLASH_PREFETCH_EN
      pbuf_q   <= 16'h0000;
      paddr_q  <= '0;
      pvalid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      wa_q     <= wa_d;
      byte_q   <= byte_d;
      odd_q    <= odd_d;
      w0_q     <= w0_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      ce_n_q   <= ce_n_d;
`ifdef FLASH_PREFETCH_EN
      pbuf_q   <= pbuf_d;
      paddr_q  <= paddr_d;
      pvalid_q <= pvalid_d;
`endif
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign NF_WE    = 1'b1;
  assign NF_BYTE  = 1'b1;
  assign NF_CE    = ce_n_q;
  assign NF_OE    = ce_n_q;
  assign NF_A     = {PageBits, a_q};

endmodule

// File: tb/tb_wb_flash_rd_cntrlr.sv
// Directed self-checking bench for wb_flash_rd_cntrlr (ADDR_W=17, WAIT_CYC=2, PAGE=0).
module tb_wb_flash_rd_cntrlr;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, bop;
  logic [16:0] adr;
  logic [15:0] dat;
  logic        ack;
  logic        nf_we, nf_byte, nf_ce, nf_oe;
  logic [21:1] nf_a;
  logic [15:0] nf_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_flash_rd_cntrlr #(
    .ADDR_W   (17),
    .WAIT_CYC (2),
    .PAGE     (0)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_adr_i  (adr),
    .wb_byte_i (bop),
    .wb_dat_o  (dat),
    .wb_ack_o  (ack),
    .NF_WE     (nf_we),
    .NF_BYTE   (nf_byte),
    .NF_CE     (nf_ce),
    .NF_OE     (nf_oe),
    .NF_A      (nf_a),
    .NF_D      (nf_d)
  );

  // Flash contents; bus floats high when the chip is not selected.
  function automatic logic [15:0] flash_word(input logic [15:0] w);
    case (w)
      16'd8:    return 16'hBEEF;
      16'd9:    return 16'h1234;
      16'd20:   return 16'h2020;
      16'hFFFF: return 16'hAB12;
      16'd0:    return 16'h5A66;
      default:  return {w[7:0], ~w[7:0]};
    endcase
  endfunction

  assign nf_d = (!nf_ce && !nf_oe) ? flash_word(nf_a[16:1]) : 16'hFFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [16:0] a, input logic b);
    adr = a;
    bop = b;
    stb = 1'b1;
    cyc = 1'b1;
  endtask

  task automatic stop();
    stb = 1'b0;
    cyc = 1'b0;
  endtask

  // Called in cycle 0; counts cycles until ack, bounded.
  task automatic wait_ack(input string tag, input int lat, input logic [15:0] exp_dat);
    int n;
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_dat"}, {16'h0, dat}, {16'h0, exp_dat});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    stb = 1'b0;
    cyc = 1'b0;
    bop = 1'b0;
    adr = '0;
    #1;
    idle(3);
    rst = 1'b0;
    tick();

    // Reset / idle state
    check("rst_ce", nf_ce, 1);
    check("rst_oe", nf_oe, 1);
    check("rst_ack", ack, 0);
    check("rst_dat", dat, 0);
    check("rst_a", nf_a, 0);
    check("rst_we_byte", {nf_we, nf_byte}, 2'b11);

    // Aligned word read, word 8
    start(17'h00010, 1'b0);
    check("al_c0_ack", ack, 0);
    tick();
    check("al_c1_a", nf_a, 21'd8);
    check("al_c1_ceoe", {nf_ce, nf_oe}, 2'b00);
    check("al_c1_ack", ack, 0);
    tick();
    check("al_c2_ack", ack, 0);
    check("al_c2_a", nf_a, 21'd8);
    tick();
    check("al_c3_ack", ack, 1);
    check("al_c3_dat", dat, 16'hBEEF);
    check("al_c3_ce", nf_ce, 1);
    stop();
    tick();
    check("al_c4_ack", ack, 0);
    check("al_c4_dat_hold", dat, 16'hBEEF);
    idle(4);

    // Byte reads, odd then even lane
    start(17'h00011, 1'b1);
    wait_ack("byte_hi", 3, 16'h00BE);
    stop();
    tick();
    check("byte_hi_ackdrop", ack, 0);
    idle(4);
    start(17'h00010, 1'b1);
    wait_ack("byte_lo", 3, 16'h00EF);
    stop();
    idle(5);

    // Unaligned word read: words 8 then 9
    start(17'h00011, 1'b0);
    tick();
    check("un_c1_a", nf_a, 21'd8);
    idle(2);
    check("un_c3_a", nf_a, 21'd9);
    check("un_c3_ce", nf_ce, 0);
    tick();
    check("un_c4_ack", ack, 0);
    tick();
    check("un_c5_ack", ack, 1);
    check("un_c5_dat", dat, 16'h34BE);
    stop();
    idle(5);

    // Unaligned word at top of window: second access wraps to word 0
    start(17'h1FFFF, 1'b0);
    tick();
    check("wr_c1_a", nf_a, 21'h0FFFF);
    idle(2);
    check("wr_c3_a", nf_a, 21'h00000);
    idle(2);
    check("wr_c5_ack", ack, 1);
    check("wr_c5_dat", dat, 16'h66AB);
    stop();
    idle(5);

    // Back-to-back: strobe held through ack, next access starts the cycle after
    start(17'h00010, 1'b0);
    wait_ack("b2b_first", 3, 16'hBEEF);
    adr = 17'h00011;
    bop = 1'b1;
    tick();
    check("b2b_gap_ack", ack, 0);
    wait_ack("b2b_second", 3, 16'h00BE);
    stop();
    idle(5);

    // Abort: strobe dropped in cycle 2
    start(17'h00020, 1'b0);
    idle(2);
    stop();
    tick();
    check("ab_c3_ce", nf_ce, 1);
    check("ab_c3_ack", ack, 0);
    tick();
    check("ab_c4_ack", ack, 0);
    check("ab_dat_hold", dat, 16'h00BE);
    idle(3);

    // Reset pulsed during WAIT2 of an unaligned read
    start(17'h00011, 1'b0);
    idle(3);
    check("rw_c3_a", nf_a, 21'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stop();
    check("rw_ack", ack, 0);
    check("rw_ce", nf_ce, 1);
    check("rw_dat", dat, 0);
    check("rw_a", nf_a, 0);
    idle(3);
    check("rw_ack_later", ack, 0);

`ifdef FLASH_PREFETCH_EN
    // Prefetch: word 8 read, then word 9 served from the buffer
    start(17'h00010, 1'b0);
    wait_ack("pf_w8", 3, 16'hBEEF);
    stop();
    idle(5);
    start(17'h00012, 1'b0);
    wait_ack("pf_hit_w9", 1, 16'h1234);
    stop();
    tick();
    // Prefetch of word 10 now in flight; a new request aborts it
    start(17'h00028, 1'b0);
    wait_ack("pf_abort_w20", 3, 16'h2020);
    stop();
    idle(5);
`else
    start(17'h00010, 1'b0);
    wait_ack("np_w8", 3, 16'hBEEF);
    stop();
    idle(5);
    start(17'h00012, 1'b0);
    wait_ack("np_w9", 3, 16'h1234);
    stop();
    idle(2);
    start(17'h00028, 1'b0);
    wait_ack("np_w20", 3, 16'h2020);
    stop();
    idle(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/wb_flash_rd_cntrlr.md
Name: wb_flash_rd_cntrlr

Overview:
- Parametrised Wishbone read-only controller for the parallel NOR flash on the Spartan-3AN board.
- Serves Zet BIOS/ROM fetches: byte reads, aligned word reads, and unaligned word reads, which take two flash accesses.
- Flash access time is programmable in clocks.
- Drives flash chip-enable and output-enable only during an access.
- Sits between the Zet Wishbone bus and the NF_* pads.

Parameters:
- ADDR_W, 17: Wishbone byte-address width. Flash word address is wb_adr_i[ADDR_W-1:1].
- WAIT_CYC, 2: clocks from NF_A stable to NF_D sampled. Legal range 1..15.
- PAGE, 0: constant driven on NF_A[21:ADDR_W]. Selects the flash window.

Ports:
- wb_clk_i  in  1  clock, 13.33 MHz max.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  bus cycle.
- wb_adr_i  in  ADDR_W  byte address.
- wb_byte_i  in  1  1 = byte access, 0 = word access.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- NF_WE  out  1  constant 1.
- NF_BYTE  out  1  constant 1 (x16 mode).
- NF_CE  out  1  active-low chip enable.
- NF_OE  out  1  active-low output enable.
- NF_A  out  21 (bits 21:1)  flash word address.
- NF_D  in  16  flash data.

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, NF_CE=1, NF_OE=1, NF_A={PAGE,0}, FSM=IDLE, wait counter=0.
- Reset mid-access returns to IDLE at the next edge, with no ack.
- Accept condition: wb_stb_i & wb_cyc_i & state==IDLE & !wb_ack_o. Call the accepting cycle "cycle 0".
- Accept edge actions:
  - load wa = wb_adr_i[ADDR_W-1:1];
  - latch byte_op and odd = wb_adr_i[0];
  - drive NF_A = wa; NF_CE = NF_OE = 0;
  - load counter with WAIT_CYC-1; enter WAIT1.
- WAIT1: counter decrements each edge. At the edge where counter==0, capture NF_D into w0. Then:
  - if !byte_op & odd (unaligned word): set NF_A = wa+1, reload counter, enter WAIT2;
  - else: enter ACK and set wb_ack_o.
- WAIT2: at the edge where counter==0, capture w1, enter ACK, set wb_ack_o.
- ACK: wb_ack_o high for exactly one cycle; NF_CE = NF_OE = 1; next state IDLE.
- Read data formatting:
  - byte read: wb_dat_o = {8'h00, odd ? w0[15:8] : w0[7:0]};
  - aligned word: wb_dat_o = w0;
  - unaligned word: wb_dat_o = {w1[7:0], w0[15:8]}.
- Latency, ack high in cycle:
  - aligned/byte: WAIT_CYC+1 (3 at default);
  - unaligned word: 2*WAIT_CYC+1 (5 at default).
- wa+1 wraps modulo 2^(ADDR_W-1) inside the window. PAGE bits never change.
- Abort: wb_stb_i or wb_cyc_i low during WAIT1/WAIT2 → IDLE at next edge, NF_CE = NF_OE = 1, no ack, wb_dat_o unchanged.
- wb_stb_i held high through ack starts the next access in the cycle after ack (no idle gap is required).
- wb_dat_o holds its value until the next ack.

Optional Feature:
- Macro: FLASH_PREFETCH_EN.
- Defined:
  - After each ack, the FSM enters PREF, fetching word last+1 (last = final word read) into pbuf with the WAIT1 timing. Sets pvalid and records paddr.
  - Accepted request whose first word == paddr with pvalid: skip WAIT1; use pbuf as w0. Aligned/byte ack in cycle 1; unaligned continues to WAIT2.
  - Request arriving while PREF is in flight: abort the prefetch, clear pvalid, start a normal access in the same edge.
  - Reset clears pvalid.
- Undefined: no PREF state, no pbuf; behaviour exactly as above.

Decomposition:
- Shared include flash_cntrlr_defs.vh holds:
  - FSM state encodings (IDLE, WAIT1, WAIT2, ACK, PREF);
  - WAIT_CYC legal-range check constants.
- Sub-module flash_wait_cnt: 4-bit loadable down-counter with done flag. Instantiated once; reused for WAIT1/WAIT2/PREF.

Test Plan:
- Reset, then idle: NF_CE=1, NF_OE=1, wb_ack_o=0, wb_dat_o=0, NF_A=0.
- Aligned word read at adr 17'h00010, flash word 8 = 16'hBEEF, WAIT_CYC=2: NF_A=8 from cycle 1; ack in cycle 3 only; wb_dat_o=16'hBEEF.
- Byte reads at adr 17'h00011 and 17'h00010, word 8 = 16'hBEEF: wb_dat_o = 16'h00BE, then 16'h00EF.
- Unaligned word at adr 17'h00011, word 8 = 16'hBEEF, word 9 = 16'h1234: NF_A 8 then 9; ack in cycle 5; wb_dat_o = 16'h34BE.
- Wrap, unaligned word at adr 17'h1FFFF: second NF_A[16:1] = 0.
- Abort/reset: stb dropped in cycle 2 → no ack, NF_CE=1 next cycle. Same test with wb_rst_i pulsed mid-WAIT2 → IDLE, ack never asserted.
- FLASH_PREFETCH_EN: read word 8, then read word 9 after prefetch completes → ack in cycle 1. New request to word 20 during PREF → aborted prefetch; ack at cycle 3 with word 20 data.
